xadac_vmacc: RTL
================

XADAC_VMACC -- requirements
Module: xadac_vmacc

Interface
REQ-001 SHALL use package constants from xadac_pkg: VecLenWidth (lane-count field width), VecDataWidth (vector register width), VecSumWidth (accumulator lane width), VecElemWidth (operand element width).
REQ-002 SHALL take parameter VmaccElemSigned, default 1, meaning operand elements are two's-complement (1) or unsigned (0).
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port rstn, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port slv, xadac_if.slv modport, carrying the decode channel (dec_req/dec_rsp) and execute channel (exe_req/exe_rsp) with valid/ready pairs.

Function -- decode (combinational, state-independent)
REQ-006 SHALL drive dec_rsp_valid = dec_req_valid and dec_req_ready = dec_rsp_valid AND dec_rsp_ready.
REQ-007 SHALL drive dec_rsp.id = dec_req.id, accept=1, rd_clobber=0, vd_clobber=1, rs_read[0..1]=0, vs_read[0..2]=1.

Function -- execute (sequential)
REQ-008 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-009 SHALL drive exe_req_ready = 1 only in IDLE.
REQ-010 SHALL, on exe_req_valid AND exe_req_ready, capture id, vd_addr = instr[11:7], vlen = instr[25 +: VecLenWidth], vs_data[0..2] into registers; acc register = vs_data[2].
REQ-011 SHALL transition IDLE->BUSY on accept if vlen != 0, IDLE->RESP if vlen == 0.
REQ-012 SHALL, in BUSY, process exactly one lane per cycle with lane counter i from 0 upward: acc[VecSumWidth*i +: VecSumWidth] += ext(a_i) * ext(b_i), where a_i/b_i = vs_data[0]/[1][VecElemWidth*i +: VecElemWidth].
REQ-013 SHALL extend operands sign- or zero-wise per VmaccElemSigned; product and sum truncated to VecSumWidth (wrap-around, no saturation).
REQ-014 SHALL skip (leave unchanged) any lane whose accumulator slice or operand slice would exceed VecDataWidth; skipped lanes still consume their cycle.
REQ-015 SHALL transition BUSY->RESP in the cycle lane vlen-1 is processed; lanes >= vlen pass vs_data[2] through unchanged.
REQ-016 SHALL, in RESP, assert exe_rsp_valid with exe_rsp.id, vd_addr, vd_data = acc, vd_write=1, all other exe_rsp fields 0; all outputs held stable until exe_rsp_ready.
REQ-017 SHALL transition RESP->IDLE on exe_rsp_valid AND exe_rsp_ready; no new request accepted in that same cycle (next accept earliest one cycle later).
REQ-018 SHALL give latency accept->exe_rsp_valid of vlen+1 cycles (1 cycle for vlen=0).
REQ-019 SHALL drive exe_rsp_valid = 0 and exe_rsp = '0 outside RESP.
REQ-020 SHALL keep decode and execute channels independent; decode handshakes proceed in any FSM state.

Reset
REQ-021 SHALL, on rstn low, immediately force state=IDLE, exe_rsp_valid=0, lane counter, vlen, id, vd_addr, acc and operand registers to 0.
REQ-022 SHALL abort any in-flight BUSY/RESP operation on reset with no response ever issued for it.
REQ-023 SHALL drive exe_req_ready=1 in the first cycle after rstn deasserts.

Verification (VecElemWidth=8, VecSumWidth=32, VecDataWidth=128, signed)
REQ-024 vlen=2, a={3,-2}, b={4,5}, acc={10,20,7,9}, vd_addr=5 -> exe_rsp_valid 3 cycles after accept, vd_data lanes {22,10,7,9}, vd_addr=5, vd_write=1.
REQ-025 vlen=0, acc=0x1111_2222_3333_4444_5555_6666_7777_8888 -> response 1 cycle after accept, vd_data equals acc unchanged.
REQ-026 lane0 acc=0x7FFFFFFF, a=1, b=1, vlen=1 -> lane0 = 0x80000000 (wrap); unsigned variant a=0xFF,b=0xFF,acc=0 -> 0x0000FE01.
REQ-027 exe_rsp_ready held low 5 cycles in RESP -> response fields stable throughout, exe_req_ready=0; back-to-back second request accepted only cycle after handshake.
REQ-028 rstn pulsed low mid-BUSY (vlen=4, after 2 lanes) -> exe_rsp_valid never rises for that op, exe_req_ready=1 first cycle after release.
REQ-029 dec_req_valid=1, id=3, dec_rsp_ready toggling, FSM BUSY -> dec_rsp.id=3, accept=1, vs_read=3'b111, rs_read=0, dec_req_ready follows dec_rsp_ready.

Source files
------------

// File: rtl/xadac_pkg.sv
// Shared widths and channel payload types for the xadac coprocessor port.
// Decode channel: dec_req_t / dec_rsp_t. Execute channel: exe_req_t / exe_rsp_t.
package xadac_pkg;

  localparam int unsigned IdWidth      = 4;
  localparam int unsigned InstrWidth   = 32;
  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned RegDataWidth = 32;
  localparam int unsigned VecLenWidth  = 3;    // lane-count field width
  localparam int unsigned VecDataWidth = 128;  // vector register width
  localparam int unsigned VecSumWidth  = 32;   // accumulator lane width
  localparam int unsigned VecElemWidth = 8;    // operand element width

  typedef struct packed {
    logic [IdWidth-1:0]    id;
    logic [InstrWidth-1:0] instr;
  } dec_req_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               accept;
    logic               rd_clobber;
    logic               vd_clobber;
    logic [1:0]         rs_read;
    logic [2:0]         vs_read;
  } dec_rsp_t;

  typedef struct packed {
    logic [IdWidth-1:0]                 id;
    logic [InstrWidth-1:0]              instr;
    logic [1:0][RegDataWidth-1:0]       rs_data;
    logic [2:0][VecDataWidth-1:0]       vs_data;
  } exe_req_t;

  typedef struct packed {
    logic [IdWidth-1:0]      id;
    logic [RegAddrWidth-1:0] rd_addr;
    logic [RegDataWidth-1:0] rd_data;
    logic                    rd_write;
    logic [RegAddrWidth-1:0] vd_addr;
    logic [VecDataWidth-1:0] vd_data;
    logic                    vd_write;
  } exe_rsp_t;

endpackage

// File: rtl/xadac_vmacc_if.sv
// Coprocessor port bundle: decode channel (dec_req/dec_rsp) and execute channel
// (exe_req/exe_rsp), each a valid/ready pair. slv = coprocessor side, mst = core side.
interface xadac_if;
  import xadac_pkg::*;

  logic     dec_req_valid;
  logic     dec_req_ready;
  dec_req_t dec_req;
  logic     dec_rsp_valid;
  logic     dec_rsp_ready;
  dec_rsp_t dec_rsp;

  logic     exe_req_valid;
  logic     exe_req_ready;
  exe_req_t exe_req;
  logic     exe_rsp_valid;
  logic     exe_rsp_ready;
  exe_rsp_t exe_rsp;

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp,
    input  exe_req_valid, exe_req, exe_rsp_ready,
    output exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp,
    output exe_req_valid, exe_req, exe_rsp_ready,
    input  exe_req_ready, exe_rsp_valid, exe_rsp
  );

endinterface

// File: rtl/xadac_vmacc.sv
// Vector multiply-accumulate coprocessor unit.
// vd[lane i] = vs2[lane i] + ext(vs0[elem i]) * ext(vs1[elem i]) for i < vlen,
// one lane per cycle. Lanes that do not fit the vector register are skipped.
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low reset
//   slv  - xadac_if slave side (decode + execute channels)
module xadac_vmacc
  import xadac_pkg::*;
#(
  parameter bit VmaccElemSigned = 1'b1  // 1: two's-complement elements, 0: unsigned
) (
  input logic   clk,
  input logic   rstn,
  xadac_if.slv  slv
);

  localparam int unsigned MaxLanes  = 2 ** VecLenWidth;
  localparam int unsigned SumLanes  = VecDataWidth / VecSumWidth;
  localparam int unsigned ElemLanes = VecDataWidth / VecElemWidth;
  localparam int unsigned FitLanes0 = (MaxLanes < SumLanes) ? MaxLanes : SumLanes;
  // Only lanes whose accumulator and operand slices fit get any hardware.
  localparam int unsigned FitLanes  = (FitLanes0 < ElemLanes) ? FitLanes0 : ElemLanes;
  localparam int unsigned OpWidth   = FitLanes * VecElemWidth;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [VecLenWidth-1:0]  lane_q, lane_d;
  logic [VecLenWidth-1:0]  vlen_q, vlen_d;
  logic [IdWidth-1:0]      id_q, id_d;
  logic [RegAddrWidth-1:0] vd_addr_q, vd_addr_d;
  logic [VecDataWidth-1:0] acc_q, acc_d;
  logic [OpWidth-1:0]      op_a_q, op_a_d;
  logic [OpWidth-1:0]      op_b_q, op_b_d;

  // ---------------- decode: purely combinational ----------------
  assign slv.dec_rsp_valid = slv.dec_req_valid;
  assign slv.dec_req_ready = slv.dec_rsp_valid & slv.dec_rsp_ready;

  always_comb begin
    slv.dec_rsp            = '0;
    slv.dec_rsp.id         = slv.dec_req.id;
    slv.dec_rsp.accept     = 1'b1;
    slv.dec_rsp.rd_clobber = 1'b0;
    slv.dec_rsp.vd_clobber = 1'b1;
    slv.dec_rsp.rs_read    = 2'b00;
    slv.dec_rsp.vs_read    = 3'b111;
  end

  // ---------------- per-lane MAC datapath ----------------
  logic [FitLanes-1:0][VecSumWidth-1:0] lane_sum;

  for (genvar k = 0; k < FitLanes; k++) begin : g_lane
    logic [VecElemWidth-1:0] a, b;
    logic [VecSumWidth-1:0]  a_ext, b_ext, prod;

    assign a = op_a_q[VecElemWidth*k +: VecElemWidth];
    assign b = op_b_q[VecElemWidth*k +: VecElemWidth];

    assign a_ext = VmaccElemSigned ?
                   {{(VecSumWidth-VecElemWidth){a[VecElemWidth-1]}}, a} :
                   {{(VecSumWidth-VecElemWidth){1'b0}}, a};
    assign b_ext = VmaccElemSigned ?
                   {{(VecSumWidth-VecElemWidth){b[VecElemWidth-1]}}, b} :
                   {{(VecSumWidth-VecElemWidth){1'b0}}, b};

    // Low VecSumWidth bits are identical for signed and unsigned multiply.
    assign prod        = a_ext * b_ext;
    assign lane_sum[k] = acc_q[VecSumWidth*k +: VecSumWidth] + prod;
  end

  // ---------------- execute FSM ----------------
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    vlen_d    = vlen_q;
    id_d      = id_q;
    vd_addr_d = vd_addr_q;
    acc_d     = acc_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;

    unique case (state_q)
      StIdle: begin
        if (slv.exe_req_valid && slv.exe_req_ready) begin
          id_d      = slv.exe_req.id;
          vd_addr_d = slv.exe_req.instr[11:7];
          vlen_d    = slv.exe_req.instr[25 +: VecLenWidth];
          op_a_d    = slv.exe_req.vs_data[0][OpWidth-1:0];
          op_b_d    = slv.exe_req.vs_data[1][OpWidth-1:0];
          acc_d     = slv.exe_req.vs_data[2];
          lane_d    = '0;
          state_d   = (vlen_d == '0) ? StResp : StBusy;
        end
      end
      StBusy: begin
        // Lanes >= FitLanes match no k and so pass through, still taking a cycle.
        for (int k = 0; k < FitLanes; k++) begin
          if (lane_q == VecLenWidth'(k)) begin
            acc_d[VecSumWidth*k +: VecSumWidth] = lane_sum[k];
          end
        end
        lane_d = lane_q + VecLenWidth'(1);
        if (lane_q == vlen_q - VecLenWidth'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (slv.exe_rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      lane_q    <= '0;
      vlen_q    <= '0;
      id_q      <= '0;
      vd_addr_q <= '0;
      acc_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      vlen_q    <= vlen_d;
      id_q      <= id_d;
      vd_addr_q <= vd_addr_d;
      acc_q     <= acc_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
    end
  end

  assign slv.exe_req_ready = (state_q == StIdle);
  assign slv.exe_rsp_valid = (state_q == StResp);

  always_comb begin
    slv.exe_rsp = '0;
    if (state_q == StResp) begin
      slv.exe_rsp.id       = id_q;
      slv.exe_rsp.vd_addr  = vd_addr_q;
      slv.exe_rsp.vd_data  = acc_q;
      slv.exe_rsp.vd_write = 1'b1;
    end
  end

endmodule
